// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int REG_NUM = 16;
  localparam int IDX_W   = 4;
  localparam logic [IDX_W-1:0] ID_IDX  = 4'd0;
  localparam logic [IDX_W-1:0] CNT_IDX = 4'd15;
endpackage

// File: rtl/apb_reg_array.sv
// 16-word register storage: constant ID word, 14 R/W words, counter word supplied by the top.
module apb_reg_array
  import apb_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  ID_VALUE = 32'hA9B0_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  input  logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [REG_NUM];

  // Entries 0 and 15 are never written; their reads are served from ID_VALUE and cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    end else if (we && widx != ID_IDX && widx != CNT_IDX) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[ridx];
    if (ridx == ID_IDX)  rdata = ID_VALUE;
    if (ridx == CNT_IDX) rdata = cnt;
  end
endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states over a 16-word register file.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          SEL_IDX     = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);
  localparam logic [2:0] WAIT_L = 3'(WAIT_CYCLES);

  apb_state_e        state_q, cur_st, state_nxt;
  logic [2:0]        wcnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [31:0]       cnt_q;
  logic [31:0]       rdata;
  logic              sel, ready, wr_err;
  logic              bus_unused;

  assign sel        = Pselx[SEL_IDX];
  assign bus_unused = ^{Pselx, Paddr[31:6], Paddr[1:0]};

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (cur_st == SETUP) begin
        wcnt_q <= '0;
        idx_q  <= Paddr[5:2];
        wr_q   <= Pwrite;
      end else if (cur_st == ACCESS && wcnt_q != WAIT_L) begin
        wcnt_q <= wcnt_q + 3'd1;
      end
      if (ready) cnt_q <= cnt_q + 32'd1;
    end
  end

  // SETUP is decoded from the live bus so ACCESS coincides with the first Penable cycle.
  always_comb begin
    cur_st = state_q;
    if (state_q == IDLE && sel && !Penable) cur_st = SETUP;
    ready     = (cur_st == ACCESS) && sel && Penable && (wcnt_q == WAIT_L) && !Hreset;
    state_nxt = IDLE;
    case (cur_st)
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (sel && Penable && !ready) ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_err  = wr_q && (idx_q == ID_IDX || idx_q == CNT_IDX);
  assign Pready  = ready;
  assign Pslverr = ready && wr_err;
  assign Prdata  = (ready && !wr_q) ? rdata : 32'h0;

  apb_reg_array #(
    .DATA_W   (32),
    .ID_VALUE (ID_VALUE)
  ) u_regs (
    .clk   (Hclk),
    .rst   (Hreset),
    .we    (ready && wr_q),
    .widx  (idx_q),
    .wdata (Pwdata),
    .ridx  (idx_q),
    .cnt   (cnt_q),
    .rdata (rdata)
  );
endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter SEL_IDX, default 0: index of the Pselx bit that selects this completer (0..2).
REQ-002 Parameter WAIT_CYCLES, default 0: wait states inserted per access (0..7).
REQ-003 Parameter ID_VALUE, default 32'hA9B0_0001: constant returned by register 0.
REQ-004 Hclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Hreset  input  1  reset, synchronous and active-high.
REQ-006 Pselx  input  3  APB select vector; only bit SEL_IDX is used.
REQ-007 Penable  input  1  APB access-phase indicator.
REQ-008 Pwrite  input  1  1 = write, 0 = read.
REQ-009 Paddr  input  32  byte address; word index = Paddr[5:2]; Paddr[1:0] ignored.
REQ-010 Pwdata  input  32  write data.
REQ-011 Prdata  output  32  read data.
REQ-012 Pready  output  1  transfer completion.
REQ-013 Pslverr  output  1  error response, valid only while Pready = 1.

Function
REQ-014 The register map SHALL be 16 x 32-bit words: word 0 = ID_VALUE (read-only), words 1..14 read/write, word 15 = transfer counter (read-only).
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-016 IDLE -> SETUP when sel = 1 and Penable = 0; otherwise the FSM stays in IDLE.
REQ-017 SETUP -> ACCESS unconditionally on the next edge; the wait counter loads 0; Paddr[5:2] and Pwrite are latched.
REQ-018 In ACCESS, the FSM SHALL assert Pready combinationally when the wait counter equals WAIT_CYCLES and sel = Penable = 1; otherwise the counter increments, saturating at WAIT_CYCLES.
REQ-019 With WAIT_CYCLES = 0, Pready SHALL be high in the first Penable cycle, giving zero-wait APB timing.
REQ-020 When Pready = 1, the next state is SETUP if sel = 1 and Penable = 0 on the following cycle (back-to-back transfer), else IDLE.
REQ-021 A write to words 1..14 SHALL commit Pwdata on the edge where sel, Penable and Pready are all 1; no partial or early commit.
REQ-022 A write to word 0 or word 15 SHALL NOT modify state and SHALL assert Pslverr = 1 with Pready.
REQ-023 During a read, Prdata SHALL equal the addressed word in the Pready = 1 cycle and SHALL be 32'h0 in all other cycles; Pslverr = 0 for reads.
REQ-024 The transfer counter SHALL increment by 1 on every completed transfer (Pready = 1, read or write, with or without error), wrapping 32'hFFFF_FFFF -> 0.
REQ-025 A read of word 15 SHALL return the counter value before the increment caused by that same read.
REQ-026 If sel drops or Penable drops while in ACCESS before Pready, the access SHALL abort: the FSM returns to IDLE with no write and no counter increment.
REQ-027 Penable = 1 with the FSM in IDLE (no setup phase) SHALL be ignored: Pready = 0 and no state change.
REQ-028 Changes on Paddr or Pwrite during ACCESS SHALL be ignored; the latched values from SETUP govern the transfer.
REQ-029 Pselx bits other than SEL_IDX SHALL have no effect.

Reset
REQ-030 While Hreset = 1 on a rising edge, the block SHALL set the FSM to IDLE, the wait counter to 0, words 1..14 to 0, and the transfer counter to 0.
REQ-031 Outputs during and immediately after reset: Prdata = 0, Pready = 0, Pslverr = 0.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer; any pending write SHALL be lost.

Structure
REQ-033 The state enum (IDLE, SETUP, ACCESS), the register count 16, and the word-index constants ID_IDX = 0 and CNT_IDX = 15 SHALL live in a shared package apb_pkg.
REQ-034 The storage array with its write-enable and read-mux SHALL be one sub-module, apb_reg_array; the FSM and counters SHALL stay in the top module.

Verification
REQ-035 Reset, then read word 0 with WAIT_CYCLES = 0 -> Pready in the first Penable cycle, Prdata = 32'hA9B0_0001, Pslverr = 0.
REQ-036 Write 32'h0000_00A3 to Paddr 32'h8000_0004, then read it back -> Prdata = 32'h0000_00A3; a subsequent read of word 15 returns 2.
REQ-037 WAIT_CYCLES = 3, write word 5 -> Pready low for exactly 3 Penable cycles, high on the 4th; the write lands only on that 4th edge.
REQ-038 Write 32'hDEAD_BEEF to word 0 -> Pslverr = 1 with Pready; a following read of word 0 still returns 32'hA9B0_0001.
REQ-039 WAIT_CYCLES = 2, drop Pselx[SEL_IDX] after one access cycle of a write to word 3 -> word 3 unchanged, counter unchanged, FSM in IDLE.
REQ-040 Assert Hreset during the ACCESS phase of a write to word 7 holding 32'h1234_5678 -> word 7 reads 0, counter reads 0, and Pready stays low during reset.
